// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared types and width helpers for the multiplier scheduler
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int id_wid(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The settle counter is loaded with MUL_CYCLES-1 and counts down to zero.
  function automatic int cnt_wid(input int mul_cycles);
    return (mul_cycles <= 2) ? 1 : $clog2(mul_cycles);
  endfunction

endpackage

// File: rtl/multiplier_cla.sv
// rtl/multiplier_cla.sv - unsigned array multiplier accumulating partial products with generate/propagate adders
module multiplier_cla #(
  parameter int MULTICAND_WID  = 32,
  parameter int MULTIPLIER_WID = 32
) (
  input  logic [MULTICAND_WID-1:0]                multicand,
  input  logic [MULTIPLIER_WID-1:0]               multiplier,
  output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] product
);

  localparam int P_WID = MULTICAND_WID + MULTIPLIER_WID;

  function automatic logic [P_WID-1:0] cla_add(input logic [P_WID-1:0] x,
                                               input logic [P_WID-1:0] y);
    logic [P_WID-1:0] g;
    logic [P_WID-1:0] p;
    logic [P_WID-1:0] c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    for (int i = 0; i < P_WID - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return p ^ c;
  endfunction

  logic [P_WID-1:0] acc;
  logic [P_WID-1:0] pp;

  // Full-width accumulation; the final carry out can never be set, so it is not kept.
  always_comb begin
    acc = '0;
    pp  = '0;
    for (int j = 0; j < MULTIPLIER_WID; j++) begin
      pp  = multiplier[j] ? (P_WID'(multicand) << j) : '0;
      acc = cla_add(acc, pp);
    end
    product = acc;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts just after ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int best;

  // Each requester's distance from ptr+1 is unique, so the minimum picks exactly one.
  always_comb begin
    gnt  = '0;
    best = N;
    for (int j = 0; j < N; j++) begin
      if (req[j] && (((j + N - 1 - int'(ptr)) % N) < best)) begin
        best = (j + N - 1 - int'(ptr)) % N;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (req[j] && (((j + N - 1 - int'(ptr)) % N) == best)) begin
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin time-sharing of one multiplier among NUM_REQ requesters
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int A_WID      = 32,
  parameter int B_WID      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WID-1:0]     req_a,
  input  logic [NUM_REQ*B_WID-1:0]     req_b,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [id_wid(NUM_REQ)-1:0]   resp_id,
  output logic [A_WID+B_WID-1:0]       resp_product,
  output logic                         busy
);

  localparam int ID_WID  = id_wid(NUM_REQ);
  localparam int CNT_WID = cnt_wid(MUL_CYCLES);
  localparam int P_WID   = A_WID + B_WID;
  localparam logic [CNT_WID-1:0] CNT_LOAD = CNT_WID'(MUL_CYCLES - 1);
  localparam logic [ID_WID-1:0]  PTR_RST  = ID_WID'(NUM_REQ - 1);

  state_t              state_q;
  logic [ID_WID-1:0]   rr_ptr_q;
  logic [ID_WID-1:0]   tag_q;
  logic [ID_WID-1:0]   tag_d;
  logic [A_WID-1:0]    op_a_q;
  logic [A_WID-1:0]    op_a_d;
  logic [B_WID-1:0]    op_b_q;
  logic [B_WID-1:0]    op_b_d;
  logic [CNT_WID-1:0]  cnt_q;
  logic                resp_valid_q;
  logic [ID_WID-1:0]   resp_id_q;
  logic [P_WID-1:0]    resp_product_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [P_WID-1:0]    mul_p;
  logic                accept;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_WID)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  // Grants are only offered while idle; the grant itself is the handshake.
  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign accept    = |req_ready;

  always_comb begin
    tag_d  = '0;
    op_a_d = '0;
    op_b_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        tag_d  = ID_WID'(k);
        op_a_d = req_a[k*A_WID +: A_WID];
        op_b_d = req_b[k*B_WID +: B_WID];
      end
    end
  end

  // Operands stay registered for MUL_CYCLES cycles: the array is a multicycle path.
  multiplier_cla #(
    .MULTICAND_WID  (A_WID),
    .MULTIPLIER_WID (B_WID)
  ) u_mul (
    .multicand  (op_a_q),
    .multiplier (op_b_q),
    .product    (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= PTR_RST;
      tag_q          <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      cnt_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            tag_q    <= tag_d;
            rr_ptr_q <= tag_d;
            cnt_q    <= CNT_LOAD;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_WID'(1);
          end else begin
            resp_product_q <= mul_p;
            resp_id_q      <= tag_q;
            resp_valid_q   <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - randomized scoreboard bench for mult_share_sched
module tb_mult_share_sched;

  localparam int NUM_REQ    = 2;
  localparam int A_WID      = 32;
  localparam int B_WID      = 32;
  localparam int MUL_CYCLES = 2;
  localparam int ID_WID     = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);
  localparam int P_WID      = A_WID + B_WID;

  typedef struct {
    int               id;
    logic [63:0]      prod;
    int               acc;
  } exp_t;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       vld;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*A_WID-1:0] req_a;
  logic [NUM_REQ*B_WID-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_WID-1:0]        resp_id;
  logic [P_WID-1:0]         resp_product;
  logic                     busy;

  logic [A_WID-1:0] a_arr [NUM_REQ];
  logic [B_WID-1:0] b_arr [NUM_REQ];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ptr_m    = NUM_REQ - 1;
  bit   got;
  int   gk;
  bit   hold_mode;
  int   seq [4];
  int   cnt;

  bit               prev_v  = 1'b0;
  bit               prev_hs = 1'b0;
  logic [P_WID-1:0] hold_p;
  logic [ID_WID-1:0] hold_id;

  mult_share_sched #(
    .NUM_REQ    (NUM_REQ),
    .A_WID      (A_WID),
    .B_WID      (B_WID),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (vld),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_a[k*A_WID +: A_WID] = a_arr[k];
      req_b[k*B_WID +: B_WID] = b_arr[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference arbitration: first valid requester after the last one served.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (v[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick(input bit rnd);
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] one;
    int   ek;
    bit   hm;
    exp_t e;
    @(negedge clk);
    g   = req_ready;
    got = 1'b0;
    if (!rst && g != '0) begin
      ek  = rr_pick(vld, ptr_m);
      one = (ek >= 0) ? (NUM_REQ'(1) << ek) : '0;
      chk("grant", 64'(g), 64'(one));
      if (ek >= 0) begin
        e.id   = ek;
        e.prod = 64'(a_arr[ek]) * 64'(b_arr[ek]);
        e.acc  = cyc + 1;
        exp_q.push_back(e);
        ptr_m  = ek;
        got    = 1'b1;
        gk     = ek;
      end
    end
    @(posedge clk);
    #1;
    if (got) begin
      hm = rnd ? 1'($urandom_range(0, 1)) : hold_mode;
      if (hm) begin
        a_arr[gk] = rand_op();
        b_arr[gk] = rand_op();
      end else begin
        vld[gk] = 1'b0;
      end
    end
    if (rnd) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!(got && gk == k)) begin
          if (!vld[k] && $urandom_range(0, 3) == 0) begin
            vld[k]   = 1'b1;
            a_arr[k] = rand_op();
            b_arr[k] = rand_op();
          end else if (vld[k] && $urandom_range(0, 15) == 0) begin
            vld[k] = 1'b0;
          end
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic do_reset(input bit check_state);
    rst        = 1'b1;
    vld        = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    if (check_state) begin
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_product", 64'(resp_product), 64'd0);
      chk("rst_resp_id", 64'(resp_id), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    exp_q.delete();
    ptr_m = NUM_REQ - 1;
  endtask

  // Response monitor: checks every presented product against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("deassert_after_accept", 64'(resp_valid), 64'd0);
        chk("idle_after_accept", 64'(busy), 64'd0);
      end
      if (busy) chk("ready_low_when_busy", 64'(req_ready), 64'd0);
      if (resp_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp_queue", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("resp_id", 64'(resp_id), 64'(exp_q[0].id));
          chk("resp_product", 64'(resp_product), exp_q[0].prod);
          chk("latency", 64'(cyc - exp_q[0].acc), 64'(MUL_CYCLES));
        end
        hold_p  = resp_product;
        hold_id = resp_id;
      end else if (resp_valid) begin
        chk("held_product", 64'(resp_product), 64'(hold_p));
        chk("held_id", 64'(resp_id), 64'(hold_id));
      end
      prev_hs = resp_valid && resp_ready;
      if (prev_hs && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_v = resp_valid;
    end
  end

  initial begin
    rst        = 1'b1;
    vld        = '0;
    resp_ready = 1'b0;
    hold_mode  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = '0;
      b_arr[k] = '0;
    end

    // Reset, then a single 7x6 request from requester 0.
    do_reset(1'b1);
    rst        = 1'b0;
    vld[0]     = 1'b1;
    a_arr[0]   = 32'd7;
    b_arr[0]   = 32'd6;
    resp_ready = 1'b1;
    tick(1'b0);
    chk("first_idle_grant", 64'(got ? gk : -1), 64'd0);
    repeat (8) tick(1'b0);

    // Contention: both requesters held valid, grants must alternate from 0.
    do_reset(1'b0);
    rst        = 1'b0;
    resp_ready = 1'b1;
    hold_mode  = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      vld[k]   = 1'b1;
      a_arr[k] = rand_op();
      b_arr[k] = rand_op();
    end
    cnt = 0;
    for (int t = 0; t < 100 && cnt < 4; t++) begin
      tick(1'b0);
      if (got) begin
        seq[cnt] = gk;
        cnt++;
      end
    end
    chk("contention_grants", 64'(cnt), 64'd4);
    for (int i = 0; i < cnt; i++) chk("rr_order", 64'(seq[i]), 64'(i % NUM_REQ));
    vld       = '0;
    hold_mode = 1'b0;
    repeat (10) tick(1'b0);

    // Backpressure with all-ones operands.
    resp_ready = 1'b0;
    vld[0]     = 1'b1;
    a_arr[0]   = 32'hFFFF_FFFF;
    b_arr[0]   = 32'hFFFF_FFFF;
    for (int t = 0; t < 20 && !resp_valid; t++) tick(1'b0);
    chk("bp_resp_seen", 64'(resp_valid), 64'd1);
    vld[1]   = 1'b1;
    a_arr[1] = rand_op();
    b_arr[1] = rand_op();
    repeat (5) tick(1'b0);
    chk("bp_held_valid", 64'(resp_valid), 64'd1);
    chk("bp_product", 64'(resp_product), 64'hFFFF_FFFE_0000_0001);
    resp_ready = 1'b1;
    repeat (10) tick(1'b0);

    // Zero operand.
    vld[1]   = 1'b1;
    a_arr[1] = 32'h0;
    b_arr[1] = 32'h1234_5678;
    repeat (8) tick(1'b0);

    // Reset while an operation is in flight.
    vld[1]   = 1'b1;
    a_arr[1] = rand_op();
    b_arr[1] = rand_op();
    got      = 1'b0;
    for (int t = 0; t < 20 && !got; t++) tick(1'b0);
    chk("midrst_grant_seen", 64'(got), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    ptr_m = NUM_REQ - 1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_resp_product", 64'(resp_product), 64'd0);
    vld      = '1;
    a_arr[0] = 32'd3;
    b_arr[0] = 32'd5;
    a_arr[1] = rand_op();
    b_arr[1] = rand_op();
    tick(1'b0);
    chk("post_reset_tie", 64'(got ? gk : -1), 64'd0);
    repeat (12) tick(1'b0);

    // Randomized traffic with random backpressure and withdrawals.
    for (int t = 0; t < 600; t++) tick(1'b1);
    vld        = '0;
    resp_ready = 1'b1;
    repeat (20) tick(1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Time-shares one `multiplier_cla` instance between NUM_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready request channel; all requesters share one response channel tagged with the requester ID.
- Operands are registered before the multiplier. The deep combinational array gets MUL_CYCLES clock cycles to settle (declared multicycle path).
- The registered product is held until the response is accepted.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- A_WID, 32, multiplicand width.
- B_WID, 32, multiplier width.
- MUL_CYCLES, 2, cycles allowed for the multiplier to settle (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NUM_REQ*A_WID  packed multiplicands; requester k occupies bits [k*A_WID +: A_WID].
- req_b  in  NUM_REQ*B_WID  packed multipliers; requester k occupies bits [k*B_WID +: B_WID].
- resp_valid  out  1  product available.
- resp_ready  in  1  consumer accepts product.
- resp_id  out  ID_WID  index of the requester that owns the product; ID_WID = max(1, clog2(NUM_REQ)).
- resp_product  out  A_WID+B_WID  unsigned product.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - rst is synchronous, active-high.
  - While rst is high at a clk edge: state=IDLE, rr_ptr=NUM_REQ-1, op_a/op_b/resp_product=0, resp_id=0, resp_valid=0, cnt=0.
- Reset mid-operation: the in-flight operation is discarded with no response. Outputs read their reset values in the cycle after the reset edge.
- State IDLE:
  - req_ready = one-hot grant from the round-robin arbiter over req_valid, registered in no way; it is combinational from req_valid and rr_ptr.
  - Search order: rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - No req_valid high → req_ready = 0 and state stays IDLE.
  - At the handshake edge (req_valid[k] & req_ready[k]):
    - op_a ← slice k of req_a; op_b ← slice k of req_b.
    - tag ← k; rr_ptr ← k.
    - cnt ← MUL_CYCLES-1; state → BUSY.
- State BUSY:
  - req_ready = 0 for all requesters.
  - Each cycle with cnt != 0: cnt decrements.
  - Edge with cnt == 0: resp_product ← multiplier output (from op_a/op_b), resp_id ← tag, resp_valid ← 1, state → DONE.
- State DONE:
  - resp_valid, resp_id and resp_product are held stable. req_ready = 0.
  - Edge with resp_ready=1: resp_valid ← 0, state → IDLE. resp_product keeps its value.
- Latency and throughput:
  - resp_valid rises exactly MUL_CYCLES edges after the accept edge.
  - Minimum accept-to-accept spacing is MUL_CYCLES+2 cycles (BUSY×MUL_CYCLES, DONE≥1, IDLE 1).
- Inputs while not in IDLE: req_valid, req_a and req_b are ignored. Requesters hold valid and data until ready; an un-granted request may be withdrawn.
- Fairness: a requester that holds req_valid high is granted within NUM_REQ arbitration rounds.
- Arithmetic: unsigned, full width A_WID+B_WID, no truncation. 0×x yields 0. All-ones × all-ones yields (2^A_WID − 1)(2^B_WID − 1).
- resp_ready while resp_valid=0: ignored.

Decomposition:
- Shared package mult_sched_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - ID width function id_wid(n);
  - cnt width constant derived from MUL_CYCLES.
- One sub-module, rr_arbiter #(N): inputs req, ptr; output one-hot gnt, combinational.
- multiplier_cla is instantiated as the datapath with MULTICAND_WID=A_WID, MULTIPLIER_WID=B_WID.
- The FSM, counter and registers stay in mult_share_sched.

Test Plan:
- Reset then single request:
  - Stimulus: rst 2 cycles; req0 valid with a=7, b=6; resp_ready=1.
  - Required: req_ready[0]=1 in the first IDLE cycle. resp_valid=1 with product=42, id=0 exactly 2 edges after the accept (MUL_CYCLES=2), deasserting 1 cycle later.
- Round-robin contention:
  - Stimulus: req0 and req1 both held valid continuously, resp_ready=1.
  - Required: grant order is 0,1,0,1. resp_id follows the same sequence; each product is correct.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after resp_valid rises, with a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Required: resp_product=0xFFFFFFFE00000001 held stable. req_ready stays 0 throughout. IDLE is re-entered one edge after resp_ready=1.
- Zero operand:
  - Stimulus: a=0, b=0x12345678.
  - Required: product=0.
- Reset mid-operation:
  - Stimulus: assert rst during BUSY.
  - Required: next cycle busy=0, resp_valid=0, resp_product=0, no response ever issued for that operation. The next request (3×5) returns 15 with rr_ptr back at its reset value, so req0 wins ties.
- MUL_CYCLES=4 build:
  - Stimulus: same single request as the first scenario (7×6).
  - Required: resp_valid rises exactly 4 edges after accept.
